// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, FSM state encoding and counter-width helper
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous input, resets to 1 (idle-high lines)
//   clk, rst_n (async, active-low), d: async input, q: synchronised output
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b11;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with start-glitch rejection, mid-bit sampling and framing-error strobe
//   clk, rst_n (async, active-low)
//   rx: serial line (idle high, LSB first)
//   rx_data: last good byte, rx_valid: one-cycle new-data strobe
//   frame_err: one-cycle strobe on a low stop bit, rx_busy: frame in progress
//   BAUD_DIV = CLK_FREQ / BAUD_RATE must be at least 4
module uart_rx import uart_pkg::*; #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CNT_W = clog2(BAUD_DIV);
  localparam int BIT_W = clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  state_t state, state_nx;
  logic [CNT_W-1:0] baud_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic rx_s, rx_prev;
  logic fall, tick_half, tick_full, stop_tick;
  sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(rx), .q(rx_s));
  assign fall = rx_prev && !rx_s;
  assign tick_half = baud_cnt == HALF_LAST;
  assign tick_full = baud_cnt == FULL_LAST;
  assign stop_tick = state == STOP && tick_full;
  assign rx_busy = state != IDLE;
  // the half-bit check in START re-centres the counter so every later tick lands mid-bit
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = fall ? START : IDLE;
      START:   state_nx = tick_half ? (rx_s ? IDLE : DATA) : START;
      DATA:    state_nx = tick_full && bit_cnt == BIT_LAST ? STOP : DATA;
      STOP:    state_nx = tick_full ? IDLE : STOP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      rx_prev   <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      rx_prev   <= rx_s;
      baud_cnt  <= state == IDLE || state_nx != state || tick_full ? '0 : baud_cnt + 1'b1;
      rx_valid  <= stop_tick && rx_s;
      frame_err <= stop_tick && !rx_s;
      if (state == DATA && tick_full) begin
        shift   <= {rx_s, shift[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (stop_tick && rx_s) rx_data <= shift;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven, hand-sequenced and randomised checks of uart_rx at BAUD_DIV=10
module tb_uart_rx;
  localparam int BAUD_DIV = 10;
  localparam int HALF_DIV = 5;
  localparam int LAT = HALF_DIV + 9 * BAUD_DIV + 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, rx_busy;
  uart_rx #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .rx_busy(rx_busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {bit v; logic [7:0] d; int c;} ev_t;
  ev_t evq[$];
  bit last_strobe = 1'b0;
  always @(negedge clk) begin
    if (rx_valid || frame_err) begin
      evq.push_back('{rx_valid, rx_data, cyc});
      n_chk++;
      if ((rx_valid && frame_err) || last_strobe) begin
        n_fail++;
        $display("FAIL strobe_rule: valid=%b err=%b prev_cycle_strobe=%b, required one exclusive single-cycle strobe",
                 rx_valid, frame_err, last_strobe);
      end
    end
    last_strobe = rx_valid || frame_err;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // p2 is the bit period in half clocks, so 21 gives alternating 10/11-clock bits
  task automatic send(input logic [7:0] b, input bit stop, input int p2, output int t0);
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      rx = k == 0 ? 1'b0 : k == 9 ? stop : b[k-1];
      hold((p2 * (k + 1)) / 2 - (p2 * k) / 2);
    end
  endtask
  typedef struct {logic [7:0] d; bit stop; int gap; int p2; bit exp_v; logic [7:0] exp_d;} vec_t;
  vec_t tbl[7];
  int t0s[7];
  initial begin
    int base, t0, busy_cnt, n;
    logic [7:0] b, last_good;
    bit stop;
    ev_t exp_q[$];
    tbl = '{
      '{8'h55, 1'b1, 20, 20, 1'b1, 8'h55},
      '{8'hA3, 1'b1,  0, 20, 1'b1, 8'hA3},
      '{8'h00, 1'b1,  0, 20, 1'b1, 8'h00},
      '{8'hFF, 1'b1, 15, 20, 1'b1, 8'hFF},
      '{8'h3C, 1'b0, 15, 20, 1'b0, 8'hFF},
      '{8'h81, 1'b1, 15, 20, 1'b1, 8'h81},
      '{8'hC5, 1'b1, 15, 21, 1'b1, 8'hC5}
    };
    hold(3);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_rx_busy", rx_busy, 1'b0);
    rst_n = 1'b1;
    hold(5);
    base = evq.size();
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].d, tbl[i].stop, tbl[i].p2, t0s[i]);
      rx = 1'b1;
      hold(tbl[i].gap);
    end
    hold(30);
    check("tbl_event_count", evq.size() - base, 7);
    for (int i = 0; i < 7 && base + i < evq.size(); i++) begin
      check($sformatf("tbl%0d_valid_not_err", i), evq[base+i].v, tbl[i].exp_v);
      check($sformatf("tbl%0d_data", i), evq[base+i].d, tbl[i].exp_d);
      check_rng($sformatf("tbl%0d_latency", i), evq[base+i].c - t0s[i], LAT - 1, LAT + 1);
    end
    base = evq.size();
    rx = 1'b0;
    hold(3);
    rx = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_busy) busy_cnt++;
    end
    check_rng("glitch_busy_cycles", busy_cnt, 1, 9);
    check("glitch_back_idle", rx_busy, 1'b0);
    check("glitch_no_strobe", evq.size() - base, 0);
    @(posedge clk);
    #1;
    base = evq.size();
    send(8'h3C, 1'b0, 20, t0);
    hold(50);
    check("break_event_count", evq.size() - base, 1);
    if (evq.size() > base) check("break_is_frame_err", evq[base].v, 1'b0);
    check("break_data_held", rx_data, 8'hC5);
    check("break_idle", rx_busy, 1'b0);
    rx = 1'b1;
    hold(10);
    base = evq.size();
    send(8'h81, 1'b1, 20, t0);
    hold(30);
    check("after_break_count", evq.size() - base, 1);
    if (evq.size() > base) begin
      check("after_break_valid", evq[base].v, 1'b1);
      check("after_break_data", evq[base].d, 8'h81);
    end
    base = evq.size();
    b = 8'h7E;
    rx = 1'b0;
    hold(10);
    for (int j = 0; j < 4; j++) begin
      rx = b[j];
      hold(10);
    end
    rx = b[4];
    hold(5);
    rst_n = 1'b0;
    #1;
    check("midreset_rx_data", rx_data, 8'h00);
    check("midreset_busy", rx_busy, 1'b0);
    hold(3);
    rx = 1'b1;
    rst_n = 1'b1;
    hold(150);
    check("midreset_no_strobe", evq.size() - base, 0);
    check("midreset_data_zero", rx_data, 8'h00);
    send(8'h12, 1'b1, 20, t0);
    rx = 1'b1;
    hold(30);
    check("post_reset_count", evq.size() - base, 1);
    if (evq.size() > base) begin
      check("post_reset_valid", evq[base].v, 1'b1);
      check("post_reset_data", evq[base].d, 8'h12);
    end
    base = evq.size();
    last_good = 8'h12;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      stop = $urandom_range(0, 7) != 0;
      send(b, stop, 20, t0);
      rx = 1'b1;
      hold($urandom_range(stop ? 0 : 1, 12));
      if (stop) last_good = b;
      exp_q.push_back('{stop, last_good, 0});
    end
    hold(30);
    check("rand_event_count", evq.size() - base, exp_q.size());
    n = exp_q.size() < evq.size() - base ? exp_q.size() : evq.size() - base;
    for (int i = 0; i < n; i++) begin
      check($sformatf("rand%0d_valid_not_err", i), evq[base+i].v, exp_q[i].v);
      check($sformatf("rand%0d_data", i), evq[base+i].d, exp_q[i].d);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
